// File: rtl/nav_pkg.sv
// Shared direction encoding for the snake direction controller.
// Build option: NAV_SYNC_EN adds a two-flop button synchroniser in nav_chan.
package nav_pkg;

    localparam int DIR_W = 2;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Bit 0 separates the vertical pair (UP/DOWN) from the horizontal pair (LEFT/RIGHT).
    function automatic logic is_perp(input dir_e a, input dir_e b);
        logic [DIR_W-1:0] av;
        logic [DIR_W-1:0] bv;
        av = a;
        bv = b;
        return av[0] != bv[0];
    endfunction

endpackage

// File: rtl/nav_chan.sv
// One player: press edge detect, perpendicular filter, turn FIFO and direction register.
// Build option: NAV_SYNC_EN inserts a two-flop synchroniser (reset to 1) ahead of edge detect.
module nav_chan
    import nav_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_up,
    input  logic btn_left,
    input  logic btn_down,
    input  logic btn_right,
    input  logic tick,
    output dir_e state,
    output logic turned,
    output logic dropped
);

    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [3:0] btn_raw;
    logic [3:0] btn_s;

    assign btn_raw = {btn_right, btn_down, btn_left, btn_up};

`ifdef NAV_SYNC_EN
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign btn_s = sync2_q;
`else
    assign btn_s = btn_raw;
`endif

    logic [3:0]    prev_q, prev_d;
    dir_e          fifo_q [QDEPTH];
    dir_e          fifo_d [QDEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    dir_e          state_q, state_d;
    logic          turned_q, turned_d;
    logic          dropped_q, dropped_d;

    logic [3:0]    press;
    logic          req_vld;
    dir_e          req_dir;
    dir_e          ref_dir;
    logic          accept;
    logic          pop;
    logic          push;
    logic [CW-1:0] wr_idx;

    always_comb begin
        prev_d  = btn_s;
        press   = btn_s & ~prev_q;
        req_vld = |press;
        req_dir = DIR_UP;
        if (press[1])      req_dir = DIR_LEFT;
        else if (press[3]) req_dir = DIR_RIGHT;
        else if (press[2]) req_dir = DIR_DOWN;
        else if (press[0]) req_dir = DIR_UP;

        // New requests are judged against the last queued turn, not the live direction.
        ref_dir = state_q;
        for (int i = 0; i < QDEPTH; i++) begin
            if (cnt_q != '0 && CW'(i) == cnt_q - 1'b1) ref_dir = fifo_q[i];
        end

        accept    = req_vld && is_perp(req_dir, ref_dir);
        pop       = tick && (cnt_q != '0);
        push      = accept && ((cnt_q != FULL) || pop);
        dropped_d = accept && (cnt_q == FULL) && !pop;
        wr_idx    = pop ? cnt_q - 1'b1 : cnt_q;

        fifo_d = fifo_q;
        if (pop) begin
            for (int i = 0; i < QDEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (push && CW'(i) == wr_idx) fifo_d[i] = req_dir;
        end

        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        state_d  = pop ? fifo_q[0] : state_q;
        turned_d = pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 4'hF;
            cnt_q     <= '0;
            state_q   <= DIR_UP;
            turned_q  <= 1'b0;
            dropped_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) fifo_q[i] <= DIR_UP;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            turned_q  <= turned_d;
            dropped_q <= dropped_d;
            fifo_q    <= fifo_d;
        end
    end

    assign state   = state_q;
    assign turned  = turned_q;
    assign dropped = dropped_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// Multi-player snake direction controller: one nav_chan per player, common TICK.
// Build option: NAV_SYNC_EN enables per-button synchronisers inside each channel.
module snake_dir_ctrl
    import nav_pkg::*;
#(
    parameter int PLAYERS = 1,
    parameter int QDEPTH  = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [PLAYERS-1:0]     BTN_UP,
    input  logic [PLAYERS-1:0]     BTN_LEFT,
    input  logic [PLAYERS-1:0]     BTN_DOWN,
    input  logic [PLAYERS-1:0]     BTN_RIGHT,
    input  logic                   TICK,
    output logic [2*PLAYERS-1:0]   STATE,
    output logic [PLAYERS-1:0]     TURNED,
    output logic [PLAYERS-1:0]     DROPPED
);

    for (genvar p = 0; p < PLAYERS; p++) begin : g_chan
        dir_e chan_state;

        nav_chan #(
            .QDEPTH (QDEPTH)
        ) u_chan (
            .clk       (CLK),
            .rst_n     (RESET),
            .btn_up    (BTN_UP[p]),
            .btn_left  (BTN_LEFT[p]),
            .btn_down  (BTN_DOWN[p]),
            .btn_right (BTN_RIGHT[p]),
            .tick      (TICK),
            .state     (chan_state),
            .turned    (TURNED[p]),
            .dropped   (DROPPED[p])
        );

        assign STATE[2*p +: 2] = chan_state;
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed scoreboard bench for snake_dir_ctrl (two players, two-entry queues, default build).
module tb_snake_dir_ctrl;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] BTN_UP = '0;
    logic [1:0] BTN_LEFT = '0;
    logic [1:0] BTN_DOWN = '0;
    logic [1:0] BTN_RIGHT = '0;
    logic       TICK = 1'b0;
    logic [3:0] STATE;
    logic [1:0] TURNED;
    logic [1:0] DROPPED;

    snake_dir_ctrl #(
        .PLAYERS (2),
        .QDEPTH  (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .BTN_UP    (BTN_UP),
        .BTN_LEFT  (BTN_LEFT),
        .BTN_DOWN  (BTN_DOWN),
        .BTN_RIGHT (BTN_RIGHT),
        .TICK      (TICK),
        .STATE     (STATE),
        .TURNED    (TURNED),
        .DROPPED   (DROPPED)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            0:       return STATE;
            1:       return {2'b00, TURNED};
            default: return {2'b00, DROPPED};
        endcase
    endfunction

    task automatic drive(input logic [1:0] up, input logic [1:0] left,
                         input logic [1:0] down, input logic [1:0] right, input logic tk);
        BTN_UP    = up;
        BTN_LEFT  = left;
        BTN_DOWN  = down;
        BTN_RIGHT = right;
        TICK      = tk;
    endtask

    task automatic cyc(input string tag, input logic [3:0] e_state,
                       input logic [1:0] e_turn, input logic [1:0] e_drop);
        sb.push_back('{tag, 0, e_state});
        sb.push_back('{tag, 1, {2'b00, e_turn}});
        sb.push_back('{tag, 2, {2'b00, e_drop}});
        @(posedge CLK);
        #1;
        while (sb.size() > 0) begin
            exp_t       e;
            logic [3:0] obs;
            string      nm;
            e   = sb.pop_front();
            obs = observe(e.sel);
            nm  = (e.sel == 0) ? "STATE" : (e.sel == 1) ? "TURNED" : "DROPPED";
            n_vec++;
            assert (obs === e.exp) else begin
                n_bad++;
                $error("FAIL %s.%s observed=%h expected=%h", e.tag, nm, obs, e.exp);
            end
        end
    endtask

    initial begin
        // reset with LEFT held on player 0, then release reset while still held
        drive(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        cyc("rst0", 4'h0, 2'b00, 2'b00);
        cyc("rst1", 4'h0, 2'b00, 2'b00);
        RESET = 1'b1;
        drive(2'b00, 2'b01, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 10; i++) cyc("held_left", 4'h0, 2'b00, 2'b00);

        // single LEFT press then TICK
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0); cyc("release",    4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b01, 2'b00, 2'b00, 1'b0); cyc("left_press", 4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("left_tick",  4'h1, 2'b01, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0); cyc("left_after", 4'h1, 2'b00, 2'b00);

        // back to UP, then opposite press ignored, then RIGHT, DOWN queued
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0); cyc("up_press",  4'h1, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("up_tick",   4'h0, 2'b01, 2'b00);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0); cyc("opp_press", 4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("opp_tick",  4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b01, 1'b0); cyc("r_press",   4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0); cyc("d_press",   4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0); cyc("rd_idle",   4'h0, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("rd_tick1",  4'h3, 2'b01, 2'b00);
        cyc("rd_tick2", 4'h2, 2'b01, 2'b00);
        cyc("rd_tick3", 4'h2, 2'b00, 2'b00);

        // LEFT, DOWN fill the queue; RIGHT is dropped
        drive(2'b00, 2'b01, 2'b00, 2'b00, 1'b0); cyc("f_left",  4'h2, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0); cyc("f_down",  4'h2, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b01, 1'b0); cyc("f_right", 4'h2, 2'b00, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0); cyc("f_idle",  4'h2, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("f_tick1", 4'h1, 2'b01, 2'b00);
        cyc("f_tick2", 4'h2, 2'b01, 2'b00);
        cyc("f_tick3", 4'h2, 2'b00, 2'b00);

        // full queue with RIGHT coincident with TICK: stored, queue stays full
        drive(2'b00, 2'b01, 2'b00, 2'b00, 1'b0); cyc("pp_left",       4'h2, 2'b00, 2'b00);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 1'b0); cyc("pp_up",         4'h2, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b01, 1'b1); cyc("pp_right_tick", 4'h1, 2'b01, 2'b00);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0); cyc("pp_full_again", 4'h1, 2'b00, 2'b01);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("pp_tick1",      4'h0, 2'b01, 2'b00);
        cyc("pp_tick2", 4'h3, 2'b01, 2'b00);
        cyc("pp_tick3", 4'h3, 2'b00, 2'b00);

        // reset mid-game discards the queued DOWN
        drive(2'b00, 2'b00, 2'b01, 2'b00, 1'b0); cyc("mr_down", 4'h3, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        RESET = 1'b0;
        cyc("mr_reset", 4'h0, 2'b00, 2'b00);
        RESET = 1'b1;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("mr_tick", 4'h0, 2'b00, 2'b00);

        // two players, simultaneous edges and priority
        drive(2'b10, 2'b01, 2'b00, 2'b01, 1'b0); cyc("mp_press", 4'b0000, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("mp_tick",  4'b0001, 2'b01, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b10, 1'b0); cyc("p1_right", 4'b0001, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("p1_tick",  4'b1101, 2'b10, 2'b00);
        drive(2'b01, 2'b00, 2'b01, 2'b00, 1'b0); cyc("ud_press", 4'b1101, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("ud_tick",  4'b1110, 2'b01, 2'b00);
        drive(2'b01, 2'b00, 2'b00, 2'b01, 1'b0); cyc("ru_press", 4'b1110, 2'b00, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b1); cyc("ru_tick",  4'b1111, 2'b01, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 1'b0); cyc("end",      4'b1111, 2'b00, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

Interface
REQ-001 SHALL have parameter PLAYERS, default 1, number of independent snakes/channels (1..4).
REQ-002 SHALL have parameter QDEPTH, default 2, turn-queue entries per player (1..8).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports BTN_UP, BTN_LEFT, BTN_DOWN, BTN_RIGHT  input  PLAYERS each  raw button level, bit p = player p.
REQ-006 SHALL have port TICK  input  1  one-cycle game-step strobe.
REQ-007 SHALL have port STATE  output  2*PLAYERS  current direction, bits [2p+1:2p] = player p.
REQ-008 SHALL have port TURNED  output  PLAYERS  one-cycle pulse when that player's STATE changed on TICK.
REQ-009 SHALL have port DROPPED  output  PLAYERS  one-cycle pulse when a press was discarded (queue full).

Function
REQ-010 SHALL encode directions UP=0, LEFT=1, DOWN=2, RIGHT=3.
REQ-011 SHALL detect presses as rising edges: button high now, low in the previous sampled cycle; held buttons generate no further requests.
REQ-012 SHALL take at most one request per player per cycle, priority LEFT > RIGHT > DOWN > UP among simultaneous edges.
REQ-013 SHALL define the reference direction as the queue tail if the queue is non-empty, else STATE.
REQ-014 SHALL accept a request only if it is perpendicular to the reference direction; same or opposite direction requests are silently ignored, no DROPPED.
REQ-015 SHALL push an accepted request into the player's FIFO after the edge at which it is sampled; without NAV_SYNC_EN, a press sampled at edge k is queued after edge k.
REQ-016 SHALL, on a TICK edge with a non-empty queue, pop the head into STATE and pulse TURNED for one cycle after that edge.
REQ-017 SHALL hold STATE and leave TURNED low on a TICK edge with an empty queue; no bypass of the queue.
REQ-018 SHALL allow push and pop in the same cycle: the pop takes the old head; the push is checked against the old tail; the count is unchanged.
REQ-019 SHALL, with the queue full and no pop in that cycle, discard an accepted request and pulse DROPPED; with a simultaneous pop, store the request.
REQ-020 SHALL keep players fully independent; TICK is common to all players.

Reset
REQ-021 SHALL, while RESET=0, force every STATE field to UP, every queue to empty, and TURNED and DROPPED to 0.
REQ-022 SHALL reset the previous-sample button registers to 1, so buttons held across reset release produce no press.
REQ-023 SHALL abandon queued turns when reset asserts mid-game; there is no recovery.

Configuration
REQ-024 SHALL, when NAV_SYNC_EN is defined, pass each button through a two-flop synchroniser (reset value 1) before edge detection, adding 2 cycles of press-to-queue latency.
REQ-025 SHALL, without NAV_SYNC_EN, edge-detect the raw inputs directly; the inputs are then already synchronous.

Structure
REQ-026 SHALL place the direction encodings and a 2-bit direction typedef/constant set in shared package nav_pkg.
REQ-027 SHALL implement one player (sync, edge detect, perpendicular check, FIFO, STATE register) as sub-module nav_chan, instantiated PLAYERS times in a generate loop.

Verification
REQ-028 SHALL verify: reset release with BTN_LEFT held -> STATE=0, no queue entry, TURNED=0 after 10 cycles.
REQ-029 SHALL verify: PLAYERS=1, no sync, LEFT edge at edge 5, TICK at edge 6 -> STATE=1 and TURNED=1 after edge 6.
REQ-030 SHALL verify: from UP, press DOWN then TICK -> ignored, STATE=0; press RIGHT, DOWN, no TICK, then 2 TICKs -> STATE goes 3 then 2.
REQ-031 SHALL verify: QDEPTH=2, presses LEFT, DOWN, RIGHT without TICK -> third press pulses DROPPED=1; TICKs yield 1, 2, then hold at 2.
REQ-032 SHALL verify: queue full, RIGHT edge coincident with TICK -> head popped, RIGHT stored, DROPPED=0, count stays 2.
REQ-033 SHALL verify: PLAYERS=2, LEFT and RIGHT edges together on player 0, UP on player 1, then TICK -> STATE[1:0]=1, STATE[3:2]=0.
